// File: rtl/router_pkt_framer.sv
// Store-and-forward packet framer feeding router_top: header, payload, parity.
// Optional FRAMER_ERR_INJECT_EN adds err_inject to corrupt parity bit0.
module router_pkt_framer #(
    parameter int GAP_CYCLES = 2,
    parameter int BUF_AW     = 6
) (
    input  logic       clock,
    input  logic       reset,
`ifdef FRAMER_ERR_INJECT_EN
    input  logic       err_inject,
`endif
    input  logic       cmd_valid,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    output logic       cmd_ready,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       busy,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    output logic       frm_active,
    output logic       pkt_done,
    output logic       cmd_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] HEADER  = 3'd2;
    localparam logic [2:0] PAYLOAD = 3'd3;
    localparam logic [2:0] PARITY  = 3'd4;
    localparam logic [2:0] GAP     = 3'd5;

    logic [2:0] state;
    logic [1:0] addr_q;
    logic [5:0] len_q;
    logic [5:0] count;
    logic [5:0] rd_idx;
    logic [3:0] gap_cnt;
    logic [7:0] parity;
    logic       inj_bit;
    logic [7:0] mem [2**BUF_AW];

`ifdef FRAMER_ERR_INJECT_EN
    logic inj_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            inj_q <= 1'b0;
        end else if (state == IDLE && cmd_valid) begin
            inj_q <= err_inject;
        end
    end

    assign inj_bit = inj_q;
`else
    assign inj_bit = 1'b0;
`endif

    assign cmd_ready  = (state == IDLE);
    assign s_ready    = (state == LOAD) && (count < len_q);
    assign pkt_valid  = (state == HEADER) || (state == PAYLOAD);
    assign frm_active = (state != IDLE);

    // Payload storage needs no reset; only the pointers define its contents.
    always_ff @(posedge clock) begin
        if (s_valid && s_ready) begin
            mem[BUF_AW'(count)] <= s_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= 2'd0;
            len_q    <= 6'd0;
            count    <= 6'd0;
            rd_idx   <= 6'd0;
            gap_cnt  <= 4'd0;
            parity   <= 8'h00;
            pkt_data <= 8'h00;
            pkt_done <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            cmd_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == 6'd0 || cmd_addr == 2'b11) begin
                            cmd_err <= 1'b1;
                        end else begin
                            addr_q <= cmd_addr;
                            len_q  <= cmd_len;
                            parity <= {cmd_len, cmd_addr};
                            count  <= 6'd0;
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        parity <= parity ^ s_data;
                        count  <= count + 6'd1;
                        if (count == len_q - 6'd1) begin
                            state    <= HEADER;
                            pkt_data <= {len_q, addr_q};
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        state    <= PAYLOAD;
                        rd_idx   <= 6'd0;
                        pkt_data <= mem[0];
                    end
                end
                PAYLOAD: begin
                    // Next byte is prefetched so pkt_data is stable from cycle start.
                    if (!busy) begin
                        if (rd_idx == len_q - 6'd1) begin
                            state    <= PARITY;
                            pkt_data <= parity ^ {7'd0, inj_bit};
                        end else begin
                            rd_idx   <= rd_idx + 6'd1;
                            pkt_data <= mem[BUF_AW'(rd_idx + 6'd1)];
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        pkt_done <= 1'b1;
                        pkt_data <= 8'h00;
                        gap_cnt  <= 4'd0;
                        state    <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_framer.sv
// Self-checking bench for router_pkt_framer: directed cases plus random packets
// compared against a queue-based model of the emitted byte stream.
module tb_router_pkt_framer;

    localparam int GAP = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       err_inject;
    logic       cmd_valid;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_ready;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       busy;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       frm_active;
    logic       pkt_done;
    logic       cmd_err;

    int passed = 0;
    int total  = 0;
    int held;
    logic [7:0] pl[$];
    logic [7:0] expq[$];

    router_pkt_framer #(.GAP_CYCLES(GAP), .BUF_AW(6)) dut (
        .clock(clock),
        .reset(reset),
`ifdef FRAMER_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .cmd_valid(cmd_valid),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .cmd_ready(cmd_ready),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .busy(busy),
        .pkt_data(pkt_data),
        .pkt_valid(pkt_valid),
        .frm_active(frm_active),
        .pkt_done(pkt_done),
        .cmd_err(cmd_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Model: header, payload as given, then XOR of everything before it.
    task automatic build_exp(input logic [1:0] a, input int len,
                             input logic inj);
        logic [7:0] p;
        expq = {};
        p = {len[5:0], a};
        expq.push_back(p);
        foreach (pl[i]) begin
            expq.push_back(pl[i]);
            p = p ^ pl[i];
        end
        expq.push_back(p ^ {7'd0, inj});
    endtask

    task automatic fill(input int len, input int base);
        pl = {};
        for (int i = 0; i < len; i++) begin
            if (base >= 0) pl.push_back(8'(base + i));
            else pl.push_back(8'($urandom));
        end
    endtask

    task automatic send_cmd(input logic [1:0] a, input int len,
                            input logic inj);
        @(negedge clock);
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_len    = 6'(len);
        err_inject = inj;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clock);
    endtask

    task automatic load(input int gap_first, input bit rnd);
        int k = 0;
        int cyc = 0;
        while (k < pl.size() && cyc < 1000) begin
            @(negedge clock);
            cmd_valid  = 1'b0;
            err_inject = 1'b0;
            s_data     = pl[k];
            s_valid    = rnd ? 1'($urandom) : (cyc >= gap_first);
            chk("s_ready_load", s_ready, 1);
            chk("cmd_ready_load", cmd_ready, 0);
            @(posedge clock);
            if (s_valid) k++;
            cyc++;
        end
        if (cyc >= 1000) chk("load_timeout", 0, 1);
        @(negedge clock);
        s_valid = 1'b0;
    endtask

    // Walks the expected stream; a byte advances only on an edge with busy=0.
    task automatic run_out(input int mode, input int stop_at);
        int idx = 0;
        int cyc = 0;
        bit stopped = 0;
        held = 0;
        while (idx < expq.size() && cyc < 4000 && !stopped) begin
            if (cyc > 0) @(negedge clock);
            if (stop_at >= 0 && idx == stop_at) begin
                stopped = 1;
            end else begin
                chk("pkt_data", pkt_data, expq[idx]);
                chk("pkt_valid", pkt_valid, idx < expq.size() - 1);
                if (idx == 5) held++;
                case (mode)
                    1: busy = 1'($urandom_range(0, 2) == 0);
                    2: busy = (idx == 5 && held < 4);
                    default: busy = 1'b0;
                endcase
                @(posedge clock);
                if (!busy) idx++;
                cyc++;
            end
        end
        busy = 1'b0;
        if (cyc >= 4000) chk("out_timeout", 0, 1);
        if (!stopped) begin
            @(negedge clock);
            chk("pkt_done_pulse", pkt_done, 1);
            chk("pkt_valid_gap", pkt_valid, 0);
            chk("pkt_data_gap", pkt_data, 0);
            chk("cmd_ready_gap0", cmd_ready, 0);
            for (int g = 1; g < GAP; g++) begin
                @(negedge clock);
                chk("pkt_done_once", pkt_done, 0);
                chk("cmd_ready_gap", cmd_ready, 0);
            end
            @(negedge clock);
            chk("cmd_ready_after_gap", cmd_ready, 1);
            chk("frm_active_idle", frm_active, 0);
        end
    endtask

    task automatic bad_cmd(input logic [1:0] a, input int len);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = 6'(len);
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("cmd_err_pulse", cmd_err, 1);
        chk("cmd_err_ready", cmd_ready, 1);
        chk("cmd_err_idle", frm_active, 0);
        chk("cmd_err_novalid", pkt_valid, 0);
        @(negedge clock);
        chk("cmd_err_clear", cmd_err, 0);
        chk("cmd_err_ready2", cmd_ready, 1);
    endtask

    initial begin
        logic inj;
        int len;
        logic [1:0] a;
        reset      = 1'b1;
        err_inject = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = 2'd0;
        cmd_len    = 6'd0;
        s_data     = 8'h00;
        s_valid    = 1'b0;
        busy       = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_pkt_data", pkt_data, 0);
        chk("rst_frm_active", frm_active, 0);
        reset = 1'b0;

`ifdef FRAMER_ERR_INJECT_EN
        inj = 1'b1;
`else
        inj = 1'b0;
`endif
        fill(16, 1);
        build_exp(2'd0, 16, inj);
        chk("model_parity", expq[17], inj ? 8'h51 : 8'h50);
        send_cmd(2'd0, 16, inj);
        load(0, 0);
        run_out(0, -1);

        fill(16, 1);
        build_exp(2'd0, 16, 1'b0);
        send_cmd(2'd0, 16, 1'b0);
        load(0, 0);
        run_out(2, -1);
        chk("busy_hold_cycles", held, 4);

        bad_cmd(2'd1, 0);
        bad_cmd(2'd3, 5);

        pl = {};
        pl.push_back(8'hAA);
        build_exp(2'd2, 1, 1'b0);
        send_cmd(2'd2, 1, 1'b0);
        load(5, 0);
        run_out(0, -1);

        fill(16, 8'h30);
        build_exp(2'd1, 16, 1'b0);
        send_cmd(2'd1, 16, 1'b0);
        load(0, 0);
        run_out(0, 7);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("abort_pkt_valid", pkt_valid, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_pkt_data", pkt_data, 0);
        chk("abort_frm_active", frm_active, 0);
        fill(2, -1);
        build_exp(2'd1, 2, 1'b0);
        send_cmd(2'd1, 2, 1'b0);
        load(0, 0);
        run_out(0, -1);

        for (int n = 0; n < 8; n++) begin
            a   = 2'($urandom_range(0, 2));
            len = (n == 0) ? 63 : $urandom_range(1, 63);
            fill(len, -1);
            build_exp(a, len, 1'b0);
            send_cmd(a, len, 1'b0);
            load(0, 1);
            run_out(1, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
